qsys_key_pio_in: RTL and testbench



---
 rtl/qsys_pio_pkg.sv | 19 +
 rtl/pio_debounce.sv | 68 ++++++
 rtl/qsys_key_pio_in.sv | 104 ++++++++++
 tb/tb_qsys_key_pio_in.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/qsys_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qsys_pio_pkg
// Brief    : Register map and edge-type constants shared by the Qsys PIO blocks.
// Revision : 1.0
// ============================================================================
package qsys_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/pio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pio_debounce
// Brief    : Per-bit 2-FF synchronizer followed by tick-sampled debounce.
// Revision : 1.0
// ============================================================================
module pio_debounce #(
    parameter int WIDTH        = 4,
    parameter int DEBOUNCE_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_pins,
    output logic [WIDTH-1:0] db
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= in_pins;
            r_sync <= r_meta;
        end
    end

    generate
        if (DEBOUNCE_DIV == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) r_db <= '0;
                else       r_db <= r_sync;
            end
        end else begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
            localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_DIV - 1);

            logic [CNT_W-1:0] r_cnt;
            logic [WIDTH-1:0] r_s1;
            logic             w_tick;

            assign w_tick = (r_cnt == c_last);

            // A bit flips only when the previous and current tick samples agree
            // and both differ from the debounced value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_s1  <= '0;
                    r_db  <= '0;
                end else begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        r_s1 <= r_sync;
                        r_db <= r_db ^ ((r_s1 ^ r_db) & ~(r_sync ^ r_s1));
                    end
                end
            end
        end
    endgenerate

    assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/qsys_key_pio_in.sv
`default_nettype none
// ============================================================================
// Module   : qsys_key_pio_in
// Brief    : Avalon-MM input PIO with debounce, edge capture and masked IRQ.
// Revision : 1.0
// ============================================================================
module qsys_key_pio_in
    import qsys_pio_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int EDGE_TYPE    = 0,
    parameter int DEBOUNCE_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] r_db_d;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_rd;
    logic [31:0]      w_rdata;
    logic             w_unused;

    pio_debounce #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_DIV (DEBOUNCE_DIV)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .in_pins (in_port),
        .db      (w_db)
    );

    assign w_wr   = chipselect & ~write_n;
    assign w_rd   = chipselect & ~read_n;
    assign w_rise = w_db & ~r_db_d;
    assign w_fall = ~w_db & r_db_d;
    assign w_clr  = (w_wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    // Upper write-data bits have no storage behind them.
    assign w_unused = &{1'b0, writedata};

    always_comb begin
        w_ev = w_rise | w_fall;
        case (EDGE_TYPE)
            EDGE_RISE: w_ev = w_rise;
            EDGE_FALL: w_ev = w_fall;
            default:   w_ev = w_rise | w_fall;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            PIO_ADDR_DATA:    w_rdata = 32'(w_db);
            PIO_ADDR_DIR:     w_rdata = '0;
            PIO_ADDR_IRQMASK: w_rdata = 32'(r_irqmask);
            PIO_ADDR_EDGECAP: w_rdata = 32'(r_edgecap);
            default:          w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_d     <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_db_d <= w_db;
            if (w_wr && address == PIO_ADDR_IRQMASK)
                r_irqmask <= writedata[WIDTH-1:0];
            // Set wins over a same-cycle clear so no event is lost.
            r_edgecap <= w_ev | (r_edgecap & ~w_clr);
            if (w_rd)
                r_readdata <= w_rdata;
            r_irq <= |(r_edgecap & r_irqmask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_qsys_key_pio_in.sv
`default_nettype none
// Directed bench: three instances cover bypass/rising, DEBOUNCE_DIV=4, and any-edge.
module tb_qsys_key_pio_in;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic [2:0]  cs;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  pin0, pin1, pin2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int total = 0;
    int bad   = 0;
    logic [31:0] rv;

    always #5 clk = ~clk;

    qsys_key_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_DIV(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd0), .in_port(pin0), .irq(irq0));

    qsys_key_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_DIV(4)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd1), .in_port(pin1), .irq(irq1));

    qsys_key_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_DIV(0)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd2), .in_port(pin2), .irq(irq2));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rd_of(input int idx);
        case (idx)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int idx, input logic [1:0] a, input logic [31:0] d);
        cs        = 3'b000;
        cs[idx]   = 1'b1;
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        step(1);
        cs        = 3'b000;
        write_n   = 1'b1;
        writedata = '0;
    endtask

    task automatic bus_read(input int idx, input logic [1:0] a, output logic [31:0] d);
        cs      = 3'b000;
        cs[idx] = 1'b1;
        address = a;
        read_n  = 1'b0;
        step(1);
        cs      = 3'b000;
        read_n  = 1'b1;
        d       = rd_of(idx);
    endtask

    initial begin
        reset = 1'b1; address = '0; cs = '0; read_n = 1'b1; write_n = 1'b1;
        writedata = '0; pin0 = '0; pin1 = '0; pin2 = '0;
        step(3);
        reset = 1'b0;

        // Reset state
        check("rst_irq0", {31'd0, irq0}, 32'd0);
        check("rst_irq1", {31'd0, irq1}, 32'd0);
        check("rst_rd2", rd2, 32'd0);
        bus_read(0, 2'd0, rv); check("rst_data", rv, 32'd0);
        bus_read(0, 2'd2, rv); check("rst_mask", rv, 32'd0);
        bus_read(0, 2'd3, rv); check("rst_ecap", rv, 32'd0);

        // Rising edge + IRQ, bypass debounce
        bus_write(0, 2'd2, 32'h5);
        bus_read(0, 2'd2, rv); check("mask_rb", rv, 32'h5);
        pin0 = 4'h1;
        step(4);
        check("irq_not_yet", {31'd0, irq0}, 32'd0);
        step(1);
        check("irq_rise", {31'd0, irq0}, 32'd1);
        bus_read(0, 2'd3, rv); check("ecap_bit0", rv, 32'h1);
        step(2);
        check("rd_hold", rd0, 32'h1);
        bus_read(0, 2'd0, rv); check("data_bit0", rv, 32'h1);
        bus_read(0, 2'd3, rv); check("ecap_read_keeps", rv, 32'h1);
        bus_write(0, 2'd3, 32'h1);
        check("irq_one_after_clr", {31'd0, irq0}, 32'd1);
        step(1);
        check("irq_cleared", {31'd0, irq0}, 32'd0);

        // Masked bit
        pin0 = 4'h3;
        step(6);
        bus_read(0, 2'd3, rv); check("ecap_masked", rv, 32'h2);
        check("irq_masked", {31'd0, irq0}, 32'd0);

        // Clear collision: bit2 edge arrives as bits 1/2 are written to clear
        pin0 = 4'h7;
        step(3);
        bus_write(0, 2'd3, 32'h6);
        bus_read(0, 2'd3, rv); check("ecap_collision", rv, 32'h4);
        step(1);
        check("irq_collision", {31'd0, irq0}, 32'd1);

        // Debounce DEBOUNCE_DIV=4: short glitch rejected
        pin1 = 4'h1;
        step(3);
        pin1 = 4'h0;
        step(20);
        bus_read(1, 2'd0, rv); check("db_glitch_data", rv, 32'h0);
        bus_read(1, 2'd3, rv); check("db_glitch_ecap", rv, 32'h0);
        pin1 = 4'h1;
        step(1);
        bus_read(1, 2'd0, rv); check("db_early", rv, 32'h0);
        step(10);
        bus_read(1, 2'd0, rv); check("db_held", rv, 32'h1);
        step(2);
        bus_read(1, 2'd3, rv); check("db_ecap", rv, 32'h1);
        check("db_irq_unmasked0", {31'd0, irq1}, 32'd0);

        // Any-edge capture
        pin2 = 4'h8;
        step(5);
        bus_read(2, 2'd3, rv); check("any_rise", rv, 32'h8);
        bus_write(2, 2'd3, 32'h8);
        bus_read(2, 2'd3, rv); check("any_cleared", rv, 32'h0);
        pin2 = 4'h0;
        step(5);
        bus_read(2, 2'd3, rv); check("any_fall", rv, 32'h8);
        bus_write(2, 2'd0, 32'hF);
        bus_read(2, 2'd0, rv); check("data_ro", rv, 32'h0);
        bus_write(2, 2'd1, 32'hF);
        bus_read(2, 2'd1, rv); check("reserved", rv, 32'h0);
        check("any_irq0", {31'd0, irq2}, 32'd0);

        // Reset with a pin held high: rising edge re-captured after release
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("rerst_rd0", rd0, 32'd0);
        step(6);
        bus_read(0, 2'd3, rv); check("rerst_ecap", rv, 32'h7);
        check("rerst_irq", {31'd0, irq0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
